prime_sieve_stream: RTL and testbench
=====================================

PRIME_SIEVE_STREAM -- requirements
Module: prime_sieve_stream

Interface
- REQ-001: The block SHALL have parameter LIMIT, default 256: the sieve covers integers 0..LIMIT-1; legal range 3 <= LIMIT <= 2^W.
- REQ-002: The block SHALL have parameter W, default 9: the width of candidate and prime values.
- REQ-003: The block SHALL have parameter CW, default 9: the width of the prime counter; CW must hold the prime count below LIMIT.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous, active-low.
- REQ-006: start  input  1  request a new sieve run; sampled on the clock edge.
- REQ-007: busy  output  1  high while a run is in progress (INIT, FIND, MARK, EMIT).
- REQ-008: done  output  1  high in DONE; held until the next accepted start.
- REQ-009: prime_valid  output  1  prime_data carries a prime.
- REQ-010: prime_ready  input  1  the consumer accepts prime_data.
- REQ-011: prime_data  output  W  current prime value.
- REQ-012: prime_count  output  CW  number of primes handed over in the current or last run.

Function
- REQ-013: The block SHALL keep a LIMIT-bit candidate bitmap, in which bit k=1 means k is still a prime candidate.
- REQ-014: The FSM SHALL have the states IDLE, INIT, FIND, MARK, EMIT and DONE, encoded in registers.
- REQ-015: IDLE or DONE with start=1 SHALL go to INIT on the next edge. start SHALL be ignored in any other state.
- REQ-016: INIT (1 cycle) SHALL set the bitmap to all ones with bits 0 and 1 cleared, set p=2, clear prime_count and clear done, then go to FIND.
- REQ-017: FIND, one candidate per cycle, SHALL act as follows:
  - if p*p >= LIMIT, go to EMIT with idx=2;
  - else if bit[p]=1, go to MARK with m=p*p;
  - else set p=p+1.
- REQ-018: MARK, one index per cycle, SHALL act as follows:
  - if m < LIMIT, clear bit[m] and set m=m+p;
  - else set p=p+1 and go to FIND.
- REQ-019: The multiple register m SHALL be W+1 bits wide and p*p SHALL be computed at 2W bits, so that neither wraps. A wrapped value SHALL never clear a bit.
- REQ-020: EMIT with bit[idx]=0 SHALL advance idx by 1 per cycle, with prime_valid=0.
- REQ-021: EMIT with bit[idx]=1 SHALL drive prime_valid=1 and prime_data=idx, and SHALL hold both stable until prime_valid && prime_ready.
- REQ-022: On a handshake the block SHALL advance idx by 1 and increment prime_count by 1.
- REQ-023: prime_valid SHALL never be asserted outside EMIT.
- REQ-024: prime_data SHALL change only on a handshake or on an idx advance while prime_valid=0.
- REQ-025: When idx reaches LIMIT, EMIT SHALL drive prime_valid=0, go to DONE and set done=1.
- REQ-026: busy SHALL be registered and go high on the edge after an accepted start.
- REQ-027: In DONE, busy SHALL be 0. prime_count SHALL hold its final value until the next INIT.
- REQ-028: The primes SHALL be emitted in strictly ascending order, each exactly once per run.
- REQ-029: prime_ready=1 held constantly SHALL give 1 prime per cycle whenever the scan sits on a set bit.

Reset
- REQ-030: While rst_n=0 the block SHALL immediately hold state=IDLE, busy=0, done=0, prime_valid=0, prime_data=0 and prime_count=0.
- REQ-031: While rst_n=0 the block SHALL immediately set p=2, m=0, idx=0 and the bitmap to all ones.
- REQ-032: Reset asserted in any state, including mid-MARK or mid-handshake, SHALL abort the run. No prime SHALL be emitted after reset until a new start.
- REQ-033: After rst_n deasserts, the block SHALL stay in IDLE until start=1.

Verification
- REQ-034: LIMIT=32, ready=1, start pulse:
  - prime_data sequence SHALL be 2,3,5,7,11,13,17,19,23,29,31;
  - prime_count SHALL be 11 and done SHALL be 1.
- REQ-035: LIMIT=256, ready=1:
  - 54 primes SHALL be emitted, first 2 and last 251;
  - 4, 9, 25, 49, 121, 169 and 225 SHALL never appear;
  - prime_count SHALL be 54.
- REQ-036: LIMIT=32, prime_ready=0 for 5 cycles while prime_data=5:
  - prime_valid SHALL stay 1 and prime_data SHALL stay 5 for all 5 cycles;
  - 7 SHALL follow after ready rises;
  - the full sequence SHALL be unchanged.
- REQ-037: start re-pulsed during MARK SHALL be ignored and the output SHALL be identical to REQ-034. start in DONE SHALL clear done, reset prime_count to 0 and reproduce the same sequence.
- REQ-038: rst_n low for 1 cycle during MARK of p=3:
  - busy=0 and prime_valid=0 SHALL hold immediately;
  - there SHALL be no output until a new start;
  - the rerun SHALL give the REQ-034 sequence.

Source files
------------

// File: rtl/prime_sieve_stream_if.sv
// Stream interface for prime_sieve_stream: run control plus the prime output handshake.
// master is the sieve side, slave is the consumer/controller side.
interface prime_sieve_stream_if #(
    parameter int W  = 9,
    parameter int CW = 9
) ();
    logic          start;
    logic          busy;
    logic          done;
    logic          prime_valid;
    logic          prime_ready;
    logic [W-1:0]  prime_data;
    logic [CW-1:0] prime_count;

    modport master (
        input  start,
        input  prime_ready,
        output busy,
        output done,
        output prime_valid,
        output prime_data,
        output prime_count
    );

    modport slave (
        output start,
        output prime_ready,
        input  busy,
        input  done,
        input  prime_valid,
        input  prime_data,
        input  prime_count
    );
endinterface

// File: rtl/prime_sieve_stream.sv
// Sieve of Eratosthenes over 0..LIMIT-1 with a valid/ready stream of the primes found.
// One bitmap operation per cycle: find next base, mark its multiples, then scan and emit.
module prime_sieve_stream #(
    parameter int LIMIT = 256,
    parameter int W     = 9,
    parameter int CW    = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prime_sieve_stream_if.master bus
);
    localparam int              IW      = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W:0]      LIM_IDX = (W+1)'(LIMIT);
    localparam logic [2*W-1:0]  LIM_PP  = (2*W)'(LIMIT);
    localparam logic [LIMIT-1:0] BM_INIT = {{(LIMIT-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FIND,
        S_MARK,
        S_EMIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [LIMIT-1:0] r_bitmap;
    logic [W-1:0]     r_p;
    logic [W:0]       r_m;
    logic [W:0]       r_idx;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;

    logic [2*W-1:0]   w_pp;
    logic             w_p_bit;
    logic             w_idx_bit;
    logic             w_idx_end;
    logic             w_m_in;
    logic             w_valid;

    // Full-width square and a W+1 bit multiple keep both comparisons free of wrap-around.
    assign w_pp      = {{W{1'b0}}, r_p} * {{W{1'b0}}, r_p};
    assign w_p_bit   = r_bitmap[r_p[IW-1:0]];
    assign w_idx_end = (r_idx >= LIM_IDX);
    assign w_idx_bit = r_bitmap[r_idx[IW-1:0]];
    assign w_m_in    = (r_m < LIM_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_state_next = S_FIND;
            end
            S_FIND: begin
                if (w_pp >= LIM_PP) begin
                    w_state_next = S_EMIT;
                end else if (w_p_bit) begin
                    w_state_next = S_MARK;
                end
            end
            S_MARK: begin
                if (!w_m_in) begin
                    w_state_next = S_FIND;
                end
            end
            S_EMIT: begin
                if (w_idx_end) begin
                    w_state_next = S_DONE;
                end else begin
                    w_valid = w_idx_bit;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap <= '1;
            r_p      <= W'(2);
            r_m      <= '0;
            r_idx    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_next inside {S_INIT, S_FIND, S_MARK, S_EMIT});
            r_done <= (w_state_next == S_DONE);
            case (r_state)
                S_INIT: begin
                    r_bitmap <= BM_INIT;
                    r_p      <= W'(2);
                    r_count  <= '0;
                end
                S_FIND: begin
                    if (w_pp >= LIM_PP) begin
                        r_idx <= (W+1)'(2);
                    end else if (w_p_bit) begin
                        r_m <= w_pp[W:0];
                    end else begin
                        r_p <= r_p + W'(1);
                    end
                end
                S_MARK: begin
                    if (w_m_in) begin
                        r_bitmap[r_m[IW-1:0]] <= 1'b0;
                        r_m <= r_m + {1'b0, r_p};
                    end else begin
                        r_p <= r_p + W'(1);
                    end
                end
                S_EMIT: begin
                    // Composites are skipped silently; a prime waits here until accepted.
                    if (!w_idx_end) begin
                        if (!w_idx_bit) begin
                            r_idx <= r_idx + (W+1)'(1);
                        end else if (bus.prime_ready) begin
                            r_idx   <= r_idx + (W+1)'(1);
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.prime_valid = w_valid;
    assign bus.prime_data  = r_idx[W-1:0];
    assign bus.prime_count = r_count;
endmodule

// File: tb/tb_prime_sieve_stream.sv
// Scoreboard bench: two sieve instances (LIMIT=32 and LIMIT=256); expected primes are queued
// at each start and popped by per-instance monitors on every valid/ready handshake.
module tb_prime_sieve_stream;
    bit clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    prime_sieve_stream_if #(.W(5), .CW(6)) s_if ();
    prime_sieve_stream_if #(.W(9), .CW(9)) b_if ();

    prime_sieve_stream #(.LIMIT(32), .W(5), .CW(6)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    prime_sieve_stream #(.LIMIT(256), .W(9), .CW(9)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    int P32 [11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
    int P256 [54] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61,
                      67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137,
                      139, 149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199,
                      211, 223, 227, 229, 233, 239, 241, 251};

    int exp_s[$];
    int exp_b[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_s();
        forever begin
            @(negedge clk);
            if (s_if.prime_valid && s_if.prime_ready) begin
                if (exp_s.size() == 0) begin
                    chk("s_unexpected_prime", int'(s_if.prime_data), -1);
                end else begin
                    int e;
                    e = exp_s.pop_front();
                    chk("s_prime", int'(s_if.prime_data), e);
                    $display("small: prime %0d (expected %0d)", s_if.prime_data, e);
                end
            end
        end
    endtask

    task automatic mon_b();
        forever begin
            @(negedge clk);
            if (b_if.prime_valid && b_if.prime_ready) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_prime", int'(b_if.prime_data), -1);
                end else begin
                    int e;
                    e = exp_b.pop_front();
                    chk("b_prime", int'(b_if.prime_data), e);
                    $display("big: prime %0d (expected %0d)", b_if.prime_data, e);
                end
            end
        end
    endtask

    task automatic push_small();
        foreach (P32[i]) exp_s.push_back(P32[i]);
    endtask

    // One run of the LIMIT=32 instance; returns cycles from the accepting edge to done.
    task automatic small_run(input int repulse_at, input bit stall, output int cycles);
        bit stalled;
        stalled = 1'b0;
        s_if.start = 1'b1;
        @(posedge clk); #1;
        s_if.start = 1'b0;
        chk("s_busy_after_start", int'(s_if.busy), 1);
        chk("s_done_cleared", int'(s_if.done), 0);
        cycles = 0;
        while (!s_if.done && cycles < 500) begin
            @(posedge clk); #1;
            cycles++;
            s_if.start = (cycles == repulse_at);
            if (cycles == 2) chk("s_count_cleared", int'(s_if.prime_count), 0);
            if (stall && !stalled && s_if.prime_valid && s_if.prime_data == 5) begin
                stalled = 1'b1;
                s_if.prime_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("s_stall_valid", int'(s_if.prime_valid), 1);
                    chk("s_stall_data", int'(s_if.prime_data), 5);
                    @(posedge clk); #1;
                    cycles++;
                end
                s_if.prime_ready = 1'b1;
            end
        end
        s_if.start = 1'b0;
        chk("s_done", int'(s_if.done), 1);
        chk("s_busy_in_done", int'(s_if.busy), 0);
        chk("s_valid_in_done", int'(s_if.prime_valid), 0);
        chk("s_count", int'(s_if.prime_count), 11);
        chk("s_missing_primes", exp_s.size(), 0);
        if (stall) chk("s_stall_seen", int'(stalled), 1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        s_if.start = 1'b0;
        s_if.prime_ready = 1'b1;
        b_if.start = 1'b0;
        b_if.prime_ready = 1'b1;
        fork
            mon_s();
            mon_b();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(s_if.busy), 0);
        chk("rst_done", int'(s_if.done), 0);
        chk("rst_valid", int'(s_if.prime_valid), 0);
        chk("rst_data", int'(s_if.prime_data), 0);
        chk("rst_count", int'(s_if.prime_count), 0);
        chk("rst_big_valid", int'(b_if.prime_valid), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", int'(s_if.busy), 0);
        chk("idle_valid", int'(s_if.prime_valid), 0);

        $display("run: LIMIT=32 basic");
        push_small();
        small_run(0, 1'b0, cyc);
        chk("s_latency", cyc, 64);

        $display("run: LIMIT=32 restart from DONE with 5-cycle stall on 5");
        push_small();
        small_run(0, 1'b1, cyc);

        $display("run: LIMIT=32 start re-pulsed during MARK");
        push_small();
        small_run(5, 1'b0, cyc);
        chk("s_latency_repulse", cyc, 64);

        $display("run: LIMIT=256");
        foreach (P256[i]) exp_b.push_back(P256[i]);
        b_if.start = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        cyc = 0;
        while (!b_if.done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b_done", int'(b_if.done), 1);
        chk("b_count", int'(b_if.prime_count), 54);
        chk("b_missing_primes", exp_b.size(), 0);

        $display("run: LIMIT=32 reset during MARK of p=3");
        s_if.start = 1'b1;
        @(posedge clk); #1;
        s_if.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(s_if.busy), 0);
        chk("mid_rst_valid", int'(s_if.prime_valid), 0);
        chk("mid_rst_data", int'(s_if.prime_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_busy", int'(s_if.busy), 0);
        chk("post_rst_done", int'(s_if.done), 0);

        $display("run: LIMIT=32 rerun after reset");
        push_small();
        small_run(0, 1'b0, cyc);
        chk("s_latency_rerun", cyc, 64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
